// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // One queued fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: instruction memory port, redirect input, decode output.
// Latency: n/a (wires only).
// Backpressure: decode throttles the queue through id_ready.
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_insn;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_insn;
  logic [CW-1:0]   if_count;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_insn, if_count,
    input  imem_insn, redirect_valid, redirect_pc, id_ready
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_insn, if_count,
    output imem_insn, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO of fetch entries with a synchronous flush.
// Latency: an entry pushed at a clock edge is at the head from the next cycle.
// Backpressure: none internally; the caller must never push into a full queue.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_dat,
  input  logic                   i_pop,
  output fetch_entry_t           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Flush wins over both push and pop; popping an empty queue is ignored.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage is not reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;

  // A push into a full queue without a simultaneous pop would lose an entry.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_do_push && !w_do_pop && (r_count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch with a credit-limited queue toward decode and branch redirect.
// Latency: fetch to decode 2 cycles; redirect to first new entry valid 3 cycles.
// Backpressure: id_ready low holds the head; fetch stops once queue + in-flight fill DEPTH.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_kill;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_if_valid;
  fetch_entry_t    w_push_dat;
  fetch_entry_t    w_head_dat;
  logic [1:0]      w_unused_lsb;

  // Credit counts the outstanding fetch but not a pop happening this cycle,
  // so the response slot is always reserved before the request goes out.
  assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = rst_n & ~bus.redirect_valid & (w_used < (CW+1)'(DEPTH));

  // A response is dropped if a redirect was seen the cycle before or arrives with it.
  assign w_push     = r_inflight & ~r_kill & ~bus.redirect_valid;
  assign w_push_dat = '{pc: r_req_pc, insn: bus.imem_insn};

  assign w_if_valid = (w_count != '0) & ~bus.redirect_valid;
  assign w_pop      = w_if_valid & bus.id_ready;

  assign w_unused_lsb = bus.redirect_pc[1:0];

  // Fetch PC, in-flight tracking and response kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      if (bus.redirect_valid) r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (w_req)         r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_req) r_req_pc <= r_fetch_pc;
      r_inflight <= w_req;
      r_kill     <= bus.redirect_valid;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (bus.redirect_valid),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_count    (w_count)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.if_valid  = w_if_valid;
  assign bus.if_pc     = w_head_dat.pc;
  assign bus.if_insn   = w_head_dat.insn;
  assign bus.if_count  = w_count;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the queue depth in entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  is the rising-edge clock for all state.
REQ-005 rst_n  input  1  is the asynchronous active-low reset.
REQ-006 imem_req  output  1  indicates a fetch is issued this cycle.
REQ-007 imem_addr  output  32  is the fetch address and always equals fetch_pc.
REQ-008 imem_insn  input  32  is the instruction word, valid in the cycle after imem_req (synchronous ROM).
REQ-009 redirect_valid  input  1  is the branch/jump taken signal from the memory stage (pcsrc).
REQ-010 redirect_pc  input  32  is the branch target.
REQ-011 id_ready  input  1  means decode accepts the head entry; it is low while decode stalls.
REQ-012 if_valid  output  1  means the head entry is presented to decode.
REQ-013 if_pc  output  32  is the PC of the head entry.
REQ-014 if_insn  output  32  is the instruction word of the head entry.
REQ-015 if_count  output  $clog2(DEPTH)+1  is the current queue occupancy.

Function
REQ-016 fetch_pc SHALL be a register and SHALL increment by 4 modulo 2^32 on every cycle with imem_req=1; 32'hFFFF_FFFC wraps to 0.
REQ-017 imem_req SHALL be 1 when redirect_valid=0 and (count + inflight) < DEPTH; a pop in the same cycle SHALL NOT count as credit.
REQ-018 inflight SHALL be a 1-bit register, set by imem_req and holding req_pc, the address of the issued fetch.
REQ-019 In the cycle after a request, {req_pc, imem_insn} SHALL be pushed into the queue unless the response is killed.
REQ-020 The queue SHALL be first-word-fall-through: if_pc and if_insn show the head entry combinationally.
REQ-021 if_valid SHALL equal (count != 0) AND NOT redirect_valid.
REQ-022 A pop SHALL occur when if_valid AND id_ready.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-024 Overflow SHALL be impossible by the credit rule; a push while full is a design error and SHALL be asserted against.
REQ-025 On redirect_valid=1, the following SHALL all happen:
  - queue emptied at the clock edge;
  - pop ignored;
  - imem_req=0;
  - fetch_pc loaded with {redirect_pc[31:2], 2'b00};
  - any response arriving in the next cycle killed.
REQ-026 Redirect latency: redirect at cycle T SHALL give imem_req with the target at T+1, the push at the end of T+2, and if_valid=1 at T+3.
REQ-027 A redirect in the same cycle a response arrives SHALL discard that response.
REQ-028 On back-to-back redirects, the last redirect SHALL win, and no stale entry SHALL ever reach decode.
REQ-029 With id_ready=0 held, the queue SHALL fill to DEPTH, after which imem_req SHALL stay 0 with fetch_pc stable.
REQ-030 if_pc and if_insn are don't-care while if_valid=0, but they SHALL NOT be X after reset.

Reset
REQ-031 Asynchronous reset SHALL set:
  - fetch_pc=RESET_PC;
  - count=0, with read and write pointers at 0;
  - inflight=0, kill=0.
REQ-032 Outputs during reset SHALL be imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_insn=0, if_count=0.
REQ-033 Reset asserted mid-operation SHALL drop all queued and in-flight fetches.
REQ-034 The first imem_req SHALL occur in the first cycle after rst_n deasserts.

Structure
REQ-035 Shared package cpu_pkg SHALL hold:
  - XLEN=32;
  - the RESET_PC default;
  - the NOP constant 32'h0000_0013;
  - the fetch-entry packed struct {pc[31:0], insn[31:0]}.
REQ-036 One sub-module, fetch_fifo, SHALL be used: a generic synchronous FIFO of the fetch-entry struct with a flush input.
REQ-037 Credit, redirect and kill logic SHALL live in ifetch_queue.

Verification
REQ-038 Reset-release streaming: release reset with id_ready=1 and ROM[i]=i -> imem_addr 0,4,8,...; if_valid first at cycle 2; if_pc/if_insn pairs (0,0),(4,1),(8,2) every cycle.
REQ-039 Fill under stall: id_ready=0 for 10 cycles -> if_count reaches 4 and imem_req=0 with imem_addr=16; after id_ready=1, pcs 0,4,8,12,16 come out in order with no gap beyond 1 cycle.
REQ-040 Redirect with full queue: redirect_pc=32'h100 while the queue is full -> if_valid=0 that cycle; if_count=0 next; the first entry out is pc 32'h100 at T+3.
REQ-041 Redirect on arriving response: redirect to 32'h200 in the cycle the response for pc 8 arrives -> pc 8 is never presented; the next if_pc is 32'h200.
REQ-042 Wrap and misalignment: redirect_pc=32'hFFFF_FFFE -> fetches at FFFF_FFFC, then 0000_0000.
REQ-043 Mid-operation reset: assert rst_n low mid-stream with 3 entries queued -> all outputs take reset values immediately; after release, refetch starts at RESET_PC.
